// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction-fetch stage of the AES-128 MIPS core.
// Holds the program counter, drives the word address into the combinational
// instruction cache and registers the returned word into the IF/ID register
// under a valid/ready handshake with decode. Supports redirect with one delay
// slot, decode-initiated flush, a one-cycle post-reset boot and a sticky
// address-fault state.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   imem_addr       word address to the cache (pc[ADDR_WIDTH+1:2])
//   imem_data       instruction word returned for imem_addr
//   id_ready        decode accepts the IF/ID contents this cycle
//   id_valid        IF/ID holds a valid instruction
//   id_instr        registered instruction
//   id_pc           byte address of id_instr
//   id_pc_plus4     id_pc + 4
//   redirect_valid  branch taken / jump resolved in decode
//   redirect_pc     redirect target byte address
//   flush           squash the IF/ID contents
//   fault           sticky address fault
//   fetch_count     instructions handed to decode (wraps)
module ifetch_stage #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [31:0]           id_instr,
  output logic [31:0]           id_pc,
  output logic [31:0]           id_pc_plus4,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  flush,
  output logic                  fault,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic        valid_nxt;
  logic [31:0] instr_nxt, id_pc_nxt, id_pc_plus4_nxt;
  logic        fault_nxt;
  logic [31:0] fetch_count_nxt;
  // Redirect seen while stalled: the delay slot at pc is still unfetched
  logic        pend, pend_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        adv;

  // Word aligned and inside the cache image
  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:ADDR_WIDTH+2] == '0);
  endfunction

  assign imem_addr = pc[ADDR_WIDTH+1:2];
  assign pc_plus4  = pc + 32'd4;
  assign adv       = !id_valid || id_ready;

  // Next-state and next-register values
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    valid_nxt       = id_valid;
    instr_nxt       = id_instr;
    id_pc_nxt       = id_pc;
    id_pc_plus4_nxt = id_pc_plus4;
    fault_nxt       = fault;
    fetch_count_nxt = fetch_count;
    pend_nxt        = pend;
    pend_target_nxt = pend_target;

    case (state)
      BOOT: begin
        state_nxt = RUN;
      end

      RUN: begin
        if (id_valid && id_ready && !flush) begin
          fetch_count_nxt = fetch_count + 32'd1;
        end

        if (redirect_valid && !is_legal(redirect_pc)) begin
          // pc freezes at the offending target
          state_nxt = FAULT;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
          pc_nxt    = redirect_pc;
          pend_nxt  = 1'b0;
        end else if (adv && !is_legal(pc)) begin
          state_nxt = FAULT;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
          pend_nxt  = 1'b0;
        end else begin
          if (adv) begin
            instr_nxt       = imem_data;
            id_pc_nxt       = pc;
            id_pc_plus4_nxt = pc_plus4;
            valid_nxt       = 1'b1;
            pend_nxt        = 1'b0;
            if (redirect_valid) begin
              pc_nxt = redirect_pc;
            end else if (pend) begin
              pc_nxt = pend_target;
            end else begin
              pc_nxt = pc_plus4;
            end
          end else if (redirect_valid) begin
            // Keep pc on the delay slot; jump after it is fetched
            pend_nxt        = 1'b1;
            pend_target_nxt = redirect_pc;
          end
          if (flush) begin
            valid_nxt = 1'b0;
          end
        end
      end

      FAULT: begin
        valid_nxt = 1'b0;
        fault_nxt = 1'b1;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'd0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
      pend        <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      id_valid    <= valid_nxt;
      id_instr    <= instr_nxt;
      id_pc       <= id_pc_nxt;
      id_pc_plus4 <= id_pc_plus4_nxt;
      fault       <= fault_nxt;
      fetch_count <= fetch_count_nxt;
      pend        <= pend_nxt;
      pend_target <= pend_target_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed testbench for ifetch_stage: boot, stall, delayed branch, redirect
// under stall, flush, faults and asynchronous reset.
module tb_ifetch_stage;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc_plus4;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic          fault;
  logic [31:0]   fetch_count;

  int vectors = 0;
  int errors  = 0;

  ifetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Cache image: a few named words, the rest tagged with their word address
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      9'd0:    return 32'h8c01_0000;
      9'd1:    return 32'h8c02_0004;
      9'd2:    return 32'h8c03_0008;
      9'd15:   return 32'h337b_03fc;
      default: return {16'hC0DE, 7'd0, a};
    endcase
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({id_valid, id_instr, id_pc, id_pc_plus4, fault, fetch_count, imem_addr} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b instr=%h pc=%h pc4=%h f=%b cnt=%0d addr=%h",
               id_valid, id_instr, id_pc, id_pc_plus4, fault, fetch_count, imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    id_ready = 1'b1;
    step();
    vectors++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle: got id_valid=%b want 0", id_valid);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, id_pc_plus4, fetch_count} !== {1'b1, 32'h0, 32'h8c01_0000, 32'h4, 32'd0}) begin
      errors++;
      $display("FAIL first_fetch: got v=%b pc=%h instr=%h pc4=%h cnt=%0d want 1 0 8c010000 4 0",
               id_valid, id_pc, id_instr, id_pc_plus4, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'h4, 32'h8c02_0004, 32'd1}) begin
      errors++;
      $display("FAIL second_fetch: got v=%b pc=%h instr=%h cnt=%0d want 1 4 8c020004 1",
               id_valid, id_pc, id_instr, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'h8, 32'h8c03_0008, 32'd2}) begin
      errors++;
      $display("FAIL third_fetch: got v=%b pc=%h instr=%h cnt=%0d want 1 8 8c030008 2",
               id_valid, id_pc, id_instr, fetch_count);
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({id_valid, id_pc, id_instr, imem_addr, fetch_count} !== {1'b1, 32'h8, 32'h8c03_0008, 9'd3, 32'd2}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h addr=%0d cnt=%0d want 1 8 8c030008 3 2",
                 i, id_valid, id_pc, id_instr, imem_addr, fetch_count);
      end
    end
    id_ready = 1'b1;
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'hc, 32'hC0DE_0003, 32'd3}) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h cnt=%0d want 1 c c0de0003 3",
               id_valid, id_pc, id_instr, fetch_count);
    end
  endtask

  task automatic test_branch();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3cc;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({id_valid, id_pc, imem_addr, fetch_count} !== {1'b1, 32'h10, 9'hf3, 32'd4}) begin
      errors++;
      $display("FAIL branch1_slot: got v=%b pc=%h addr=%h cnt=%0d want 1 10 f3 4",
               id_valid, id_pc, imem_addr, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h3cc, 32'hC0DE_00F3}) begin
      errors++;
      $display("FAIL branch1_target: got v=%b pc=%h instr=%h want 1 3cc c0de00f3",
               id_valid, id_pc, id_instr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3c;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h3d0, 32'hC0DE_00F4}) begin
      errors++;
      $display("FAIL branch2_slot: got v=%b pc=%h instr=%h want 1 3d0 c0de00f4",
               id_valid, id_pc, id_instr);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, id_pc_plus4, fetch_count} !== {1'b1, 32'h3c, 32'h337b_03fc, 32'h40, 32'd7}) begin
      errors++;
      $display("FAIL branch2_target: got v=%b pc=%h instr=%h pc4=%h cnt=%0d want 1 3c 337b03fc 40 7",
               id_valid, id_pc, id_instr, id_pc_plus4, fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    step();
    vectors++;
    if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h3c, 32'd7}) begin
      errors++;
      $display("FAIL rstall_hold: got v=%b pc=%h cnt=%0d want 1 3c 7", id_valid, id_pc, fetch_count);
    end
    id_ready = 1'b1;
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'h40, 32'hC0DE_0010, 32'd8}) begin
      errors++;
      $display("FAIL rstall_slot: got v=%b pc=%h instr=%h cnt=%0d want 1 40 c0de0010 8",
               id_valid, id_pc, id_instr, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'h100, 32'hC0DE_0040, 32'd9}) begin
      errors++;
      $display("FAIL rstall_target: got v=%b pc=%h instr=%h cnt=%0d want 1 100 c0de0040 9",
               id_valid, id_pc, id_instr, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h104, 32'd10}) begin
      errors++;
      $display("FAIL rstall_next: got v=%b pc=%h cnt=%0d want 1 104 10", id_valid, id_pc, fetch_count);
    end
  endtask

  task automatic test_flush();
    flush          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    flush          = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if ({id_valid, fetch_count} !== {1'b0, 32'd10}) begin
      errors++;
      $display("FAIL flush_squash: got v=%b cnt=%0d want 0 10", id_valid, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fetch_count} !== {1'b1, 32'h20, 32'hC0DE_0008, 32'd10}) begin
      errors++;
      $display("FAIL flush_target: got v=%b pc=%h instr=%h cnt=%0d want 1 20 c0de0008 10",
               id_valid, id_pc, id_instr, fetch_count);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h24, 32'd11}) begin
      errors++;
      $display("FAIL flush_next: got v=%b pc=%h cnt=%0d want 1 24 11", id_valid, id_pc, fetch_count);
    end
  endtask

  task automatic test_fault_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3e;
    step();
    vectors++;
    if ({fault, id_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fault_entry: got fault=%b v=%b want 1 0", fault, id_valid);
    end
    redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({fault, id_valid, imem_addr} !== {1'b1, 1'b0, 9'd15}) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: got fault=%b v=%b addr=%0d want 1 0 15",
                 i, fault, id_valid, imem_addr);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #2;
    vectors++;
    if ({id_valid, id_instr, id_pc, id_pc_plus4, fault, fetch_count, imem_addr} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_mid: got v=%b instr=%h pc=%h pc4=%h f=%b cnt=%0d addr=%h",
               id_valid, id_instr, id_pc, id_pc_plus4, fault, fetch_count, imem_addr);
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reboot_cycle: got id_valid=%b want 0", id_valid);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr, fault} !== {1'b1, 32'h0, 32'h8c01_0000, 1'b0}) begin
      errors++;
      $display("FAIL reboot_fetch: got v=%b pc=%h instr=%h f=%b want 1 0 8c010000 0",
               id_valid, id_pc, id_instr, fault);
    end
  endtask

  task automatic test_runoff();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7f8;
    step();
    redirect_valid = 1'b0;
    step();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h7f8, 32'hC0DE_01FE}) begin
      errors++;
      $display("FAIL runoff_7f8: got v=%b pc=%h instr=%h want 1 7f8 c0de01fe", id_valid, id_pc, id_instr);
    end
    step();
    vectors++;
    if ({fault, id_valid, id_pc, id_pc_plus4, imem_addr} !== {1'b0, 1'b1, 32'h7fc, 32'h800, 9'd0}) begin
      errors++;
      $display("FAIL runoff_last: got f=%b v=%b pc=%h pc4=%h addr=%0d want 0 1 7fc 800 0",
               fault, id_valid, id_pc, id_pc_plus4, imem_addr);
    end
    step();
    vectors++;
    if ({fault, id_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL runoff_fault: got f=%b v=%b want 1 0", fault, id_valid);
    end
  endtask

  task automatic test_reset_pending();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    rst = 1'b1;
    #2;
    vectors++;
    if ({id_valid, fetch_count} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL pend_reset: got v=%b cnt=%0d want 0 0", id_valid, fetch_count);
    end
    step();
    rst      = 1'b0;
    id_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL pend_boot: got v=%b pc=%h want 1 0", id_valid, id_pc);
    end
    step();
    vectors++;
    if ({id_valid, id_pc} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL pend_cleared: got v=%b pc=%h want 1 4", id_valid, id_pc);
    end
    step();
    vectors++;
    if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h8, 32'd2}) begin
      errors++;
      $display("FAIL pend_seq: got v=%b pc=%h cnt=%0d want 1 8 2", id_valid, id_pc, fetch_count);
    end
  endtask

  initial begin
    rst            = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    flush          = 1'b0;
    test_reset();
    test_stall();
    test_branch();
    test_redirect_stall();
    test_flush();
    test_fault_redirect();
    test_reset_mid();
    test_runoff();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
